// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB master: FSM states, bit phases and
// the quarter-bit divider computation.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_TXBYTE,
        S_DC,
        S_RSTOP,
        S_RSTART,
        S_RXBYTE,
        S_NA,
        S_STOP,
        S_GAP
    } state_e;

    localparam logic [1:0] PHASE_Q0 = 2'd0;
    localparam logic [1:0] PHASE_Q1 = 2'd1;
    localparam logic [1:0] PHASE_Q2 = 2'd2;
    localparam logic [1:0] PHASE_Q3 = 2'd3;

    // 8 data bits plus the don't-care / NA bit
    localparam int BITS_PER_BYTE = 9;

    function automatic int qtr_calc(input int clk_hz, input int sccb_hz);
        return clk_hz / (sccb_hz * 4);
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit divider for the SCCB master.
// Ports: clk_i, rst_ni (async low), clr_i (hold at phase 0),
//        qtick_o (last cycle of a quarter), phase_o (current quarter).
module sccb_tick_gen
    import sccb_pkg::*;
#(
    parameter int QTR = 125
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    output logic       qtick_o,
    output logic [1:0] phase_o
);

    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          wrap;

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = PHASE_Q0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= PHASE_Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign qtick_o = wrap && !clr_i;
    assign phase_o = phase_q;

endmodule

// File: rtl/sccb_master.sv
// SCCB (2-wire) master for OmniVision camera register access.
// Ports: XCLK, RST (async low), start/rw/dev_id/reg_addr/wr_data request,
//        busy/done/rd_data status, SIO_C clock, SIO_D bidirectional data.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCCB_FREQ  = 100_000,
    parameter int ADDR_BYTES = 1
) (
    input  logic                    XCLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    rw,
    input  logic [7:0]              dev_id,
    input  logic [8*ADDR_BYTES-1:0] reg_addr,
    input  logic [7:0]              wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              rd_data,
    output logic                    SIO_C,
    inout  wire                     SIO_D
);

    localparam int QTR = qtr_calc(CLK_FREQ, SCCB_FREQ);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 2);
    localparam logic [2:0] IDX_ADDR_LAST = 3'(ADDR_BYTES);
    localparam logic [2:0] IDX_LAST_TX = 3'(ADDR_BYTES + 1);

    state_e                  state_q, state_d;
    logic [2:0]              bit_q, bit_d;
    logic [2:0]              byte_q, byte_d;
    logic [7:0]              tx_q, tx_d;
    logic [7:0]              rx_q, rx_d;
    logic [7:0]              rd_q, rd_d;
    logic                    rw_q, rw_d;
    logic [6:0]              dev_q, dev_d;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    done_q, done_d;

    logic       qtick;
    logic [1:0] phase;
    logic       eob;
    logic       sda_in;
    logic       scl, oe, sdo, mid;
    logic       unused_dev0;

    // The R/W bit is always generated here
    assign unused_dev0 = dev_id[0];

    sccb_tick_gen #(
        .QTR(QTR)
    ) u_tick (
        .clk_i  (XCLK),
        .rst_ni (RST),
        .clr_i  (state_q == S_IDLE),
        .qtick_o(qtick),
        .phase_o(phase)
    );

    assign eob    = qtick && (phase == PHASE_Q3);
    assign sda_in = SIO_D;

    // Byte index 0 is the write-ID, then address bytes MSB first,
    // then write data or (for reads) the read-ID.
    function automatic logic [7:0] byte_src(input logic [2:0] idx);
        logic [7:0] b;
        b = rw_q ? {dev_q, 1'b1} : data_q;
        if (idx == 3'd0) b = {dev_q, 1'b0};
        for (int i = 1; i <= ADDR_BYTES; i++) begin
            if (idx == 3'(i)) b = addr_q[8*(ADDR_BYTES-i) +: 8];
        end
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    dev_d   = dev_id[7:1];
                    addr_d  = reg_addr;
                    data_d  = wr_data;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START, S_RSTART: begin
                if (eob) begin
                    tx_d    = byte_src(byte_q);
                    bit_d   = 3'd0;
                    state_d = S_TXBYTE;
                end
            end
            S_TXBYTE: begin
                if (eob) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = 3'd0;
                        state_d = S_DC;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
            end
            S_DC: begin
                if (eob) begin
                    if (rw_q && byte_q == IDX_ADDR_LAST) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_RSTOP;
                    end else if (byte_q == IDX_LAST_TX) begin
                        if (rw_q) begin
                            byte_d  = byte_q + 3'd1;
                            state_d = S_RXBYTE;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        tx_d    = byte_src(byte_q + 3'd1);
                        state_d = S_TXBYTE;
                    end
                end
            end
            S_RSTOP: begin
                if (eob) state_d = S_RSTART;
            end
            S_RXBYTE: begin
                // Sample mid-high, i.e. at the q1->q2 boundary
                if (qtick && phase == PHASE_Q1) begin
                    rx_d = {rx_q[6:0], sda_in};
                end
                if (eob) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = 3'd0;
                        rd_d    = rx_q;
                        state_d = S_NA;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_NA: begin
                if (eob) state_d = S_STOP;
            end
            S_STOP: begin
                if (eob) state_d = S_GAP;
            end
            S_GAP: begin
                if (eob) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge XCLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign mid = (phase == PHASE_Q1) || (phase == PHASE_Q2);

    // Pin decode; START/STOP are the only places SIO_D moves with SIO_C high
    always_comb begin
        scl = 1'b1;
        oe  = 1'b0;
        sdo = 1'b1;
        unique case (state_q)
            S_START, S_RSTART: begin
                scl = (phase != PHASE_Q3);
                oe  = 1'b1;
                sdo = (phase == PHASE_Q0) || (phase == PHASE_Q1);
            end
            S_TXBYTE: begin
                scl = mid;
                oe  = 1'b1;
                sdo = tx_q[7];
            end
            S_DC, S_RXBYTE: begin
                scl = mid;
            end
            S_NA: begin
                scl = mid;
                oe  = 1'b1;
                sdo = 1'b1;
            end
            S_STOP, S_RSTOP: begin
                scl = (phase != PHASE_Q0);
                oe  = (phase != PHASE_Q3);
                sdo = (phase == PHASE_Q2);
            end
            default: ;
        endcase
    end

    assign SIO_C   = scl;
    assign SIO_D   = oe ? sdo : 1'bz;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_sccb_master.sv
// Randomised bench for sccb_master with a bit-symbol bus model,
// an open-drain slave (ACKs every byte, returns read data) and a bus decoder.
module tb_sccb_master;

    localparam int CF = 4_000_000;
    localparam int SF = 250_000;
    localparam int Q  = CF / (SF * 4);
    localparam int BT = 4 * Q;

    localparam int K_START = 0;
    localparam int K_BIT   = 1;
    localparam int K_DC    = 2;
    localparam int K_RX    = 3;
    localparam int K_NA    = 4;
    localparam int K_STOP  = 5;
    localparam int K_GAP   = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        rw_in = 1'b0;
    logic [7:0]  dev_in = '0;
    logic [7:0]  data_in = '0;
    logic [15:0] addr_in = '0;
    logic        busy1, done1, c1;
    logic        busy2, done2, c2;
    logic [7:0]  rd1, rd2;
    wire         sda1, sda2;
    logic        slave_low = 1'b0;
    logic        sel = 1'b0;

    pullup (sda1);
    pullup (sda2);
    assign sda1 = (slave_low && !sel) ? 1'b0 : 1'bz;
    assign sda2 = (slave_low && sel) ? 1'b0 : 1'bz;

    sccb_master #(
        .CLK_FREQ(CF), .SCCB_FREQ(SF), .ADDR_BYTES(1)
    ) u1 (
        .XCLK(clk), .RST(rst_n), .start(start1), .rw(rw_in),
        .dev_id(dev_in), .reg_addr(addr_in[7:0]),
        .wr_data(data_in), .busy(busy1), .done(done1),
        .rd_data(rd1), .SIO_C(c1), .SIO_D(sda1)
    );

    sccb_master #(
        .CLK_FREQ(CF), .SCCB_FREQ(SF), .ADDR_BYTES(2)
    ) u2 (
        .XCLK(clk), .RST(rst_n), .start(start2), .rw(rw_in),
        .dev_id(dev_in), .reg_addr(addr_in),
        .wr_data(data_in), .busy(busy2), .done(done2),
        .rd_data(rd2), .SIO_C(c2), .SIO_D(sda2)
    );

    logic       c_b, d_b, busy_b, done_b;
    logic [7:0] rd_b;
    assign c_b    = sel ? c2 : c1;
    assign d_b    = sel ? sda2 : sda1;
    assign busy_b = sel ? busy2 : busy1;
    assign done_b = sel ? done2 : done1;
    assign rd_b   = sel ? rd2 : rd1;

    always #5 clk = ~clk;

    int         cyc = 0;
    int         t0 = 0;
    bit         active = 1'b0;
    int         kinds[$];
    bit         vals[$];
    bit         bits[$];
    int         done_k = -1;
    logic [7:0] exp_rd [2];
    logic [7:0] rx_cur = '0;
    int         errors = 0;
    int         checks = 0;
    bit         prev_c = 1'b1;
    bit         prev_d = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endfunction

    function automatic void push(int kd, bit v);
        kinds.push_back(kd);
        vals.push_back(v);
    endfunction

    function automatic void push_byte(logic [7:0] b);
        for (int i = 7; i >= 0; i--) push(K_BIT, b[i]);
        push(K_DC, 1'b0);
    endfunction

    // Whole transaction as a list of bit-time symbols
    function automatic void build(bit r, logic [7:0] dv,
                                  logic [15:0] ad, int ab,
                                  logic [7:0] dt, logic [7:0] rx);
        kinds.delete();
        vals.delete();
        push(K_START, 1'b0);
        push_byte({dv[7:1], 1'b0});
        for (int i = ab - 1; i >= 0; i--) push_byte(ad[8*i +: 8]);
        if (!r) begin
            push_byte(dt);
        end else begin
            push(K_STOP, 1'b0);
            push(K_START, 1'b0);
            push_byte({dv[7:1], 1'b1});
            for (int i = 7; i >= 0; i--) push(K_RX, rx[i]);
            push(K_NA, 1'b1);
        end
        push(K_STOP, 1'b0);
        push(K_GAP, 1'b0);
        rx_cur = rx;
    endfunction

    function automatic bit exp_c(int kd, int q);
        case (kd)
            K_START: return q != 3;
            K_STOP:  return q != 0;
            K_GAP:   return 1'b1;
            default: return (q == 1) || (q == 2);
        endcase
    endfunction

    function automatic bit exp_d(int kd, bit v, int q);
        case (kd)
            K_START: return q < 2;
            K_STOP:  return q >= 2;
            K_DC:    return 1'b0;
            K_NA:    return 1'b1;
            K_GAP:   return 1'b1;
            default: return v;
        endcase
    endfunction

    function automatic int byte_at(int off);
        int b = 0;
        for (int i = 0; i < 8; i++) b = (b << 1) | int'(bits[off + i]);
        return b;
    endfunction

    // Open-drain slave: ACK on every 9th bit, zeros of the read byte
    always @(cyc or active) begin
        int k;
        int s;
        k = cyc - t0;
        slave_low = 1'b0;
        if (active && k >= 0 && k < kinds.size() * BT) begin
            s = k / BT;
            slave_low = (kinds[s] == K_DC) ||
                        (kinds[s] == K_RX && !vals[s]);
        end
    end

    always @(negedge clk) begin
        int k;
        int s;
        int q;
        if (rst_n) begin
            if (active) begin
                k = cyc - t0;
                if (k < kinds.size() * BT) begin
                    s = k / BT;
                    q = (k % BT) / Q;
                    if (kinds[s] == K_NA && k % BT == 0)
                        exp_rd[sel] = rx_cur;
                    chk("sio_c", int'(c_b), int'(exp_c(kinds[s], q)));
                    chk("sio_d", int'(d_b),
                        int'(exp_d(kinds[s], vals[s], q)));
                    chk("busy", int'(busy_b), 1);
                    chk("done", int'(done_b), 0);
                    if (prev_c && c_b && (d_b != prev_d))
                        chk("sda_edge_while_scl_high",
                            int'(kinds[s] == K_START ||
                                 kinds[s] == K_STOP), 1);
                    if (!prev_c && c_b) bits.push_back(d_b);
                end else begin
                    chk("done_end", int'(done_b), 1);
                    chk("busy_end", int'(busy_b), 0);
                    chk("sio_c_end", int'(c_b), 1);
                    chk("sio_d_end", int'(d_b), 1);
                    done_k = k;
                    active = 1'b0;
                end
            end else begin
                chk("idle_sio_c", int'(c_b), 1);
                chk("idle_sio_d", int'(d_b), 1);
                chk("idle_busy", int'(busy_b), 0);
                chk("idle_done", int'(done_b), 0);
            end
            chk("rd_data", int'(rd_b), int'(exp_rd[sel]));
        end
        prev_c = c_b;
        prev_d = d_b;
    end

    task automatic run(input bit s, input bit r, input logic [7:0] dv,
                       input logic [15:0] ad, input logic [7:0] dt,
                       input logic [7:0] rx, input int spur_k,
                       input int rst_k);
        int k;
        @(negedge clk);
        sel     = s;
        rw_in   = r;
        dev_in  = dv;
        addr_in = ad;
        data_in = dt;
        build(r, dv, ad, s ? 2 : 1, dt, rx);
        bits.delete();
        done_k = -1;
        if (s) start2 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        t0     = cyc;
        active = 1'b1;
        // Inputs must have been latched; scramble them
        rw_in   = 1'($urandom);
        dev_in  = 8'($urandom);
        addr_in = 16'($urandom);
        data_in = 8'($urandom);
        for (int i = 0; i < 2000 && active; i++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start2 = 1'b0;
            k = cyc - t0;
            if (k == spur_k) begin
                if (s) start2 = 1'b1;
                else start1 = 1'b1;
            end
            if (k == rst_k) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_sio_c", int'(c_b), 1);
                chk("rst_sio_d", int'(d_b), 1);
                chk("rst_busy", int'(busy_b), 0);
                chk("rst_done", int'(done_b), 0);
                chk("rst_rd_data", int'(rd_b), 0);
                active = 1'b0;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        chk("txn_finished", int'(active), 0);
        active = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         s, r;
        logic [7:0] dv, dt, rx;
        logic [15:0] ad;
        int         sp;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_c1", int'(c1), 1);
        chk("reset_c2", int'(c2), 1);
        chk("reset_d1", int'(sda1), 1);
        chk("reset_d2", int'(sda2), 1);
        chk("reset_busy1", int'(busy1), 0);
        chk("reset_busy2", int'(busy2), 0);
        chk("reset_done1", int'(done1), 0);
        chk("reset_rd1", int'(rd1), 0);
        chk("reset_rd2", int'(rd2), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run(1'b0, 1'b0, 8'h60, 16'h0012, 8'h80, 8'h00, -1, -1);
        chk("t1_len", done_k, 30 * BT);
        chk("t1_nbits", bits.size(), 28);
        chk("t1_b0", byte_at(0), 'h60);
        chk("t1_b1", byte_at(9), 'h12);
        chk("t1_b2", byte_at(18), 'h80);

        run(1'b0, 1'b1, 8'h61, 16'h000A, 8'h00, 8'h26, -1, -1);
        chk("t2_len", done_k, 41 * BT);
        chk("t2_nbits", bits.size(), 38);
        chk("t2_b0", byte_at(0), 'h60);
        chk("t2_b1", byte_at(9), 'h0A);
        chk("t2_b2", byte_at(19), 'h61);
        chk("t2_rx", byte_at(28), 'h26);
        chk("t2_na", int'(bits[36]), 1);
        chk("t2_rd", int'(rd1), 'h26);

        run(1'b1, 1'b0, 8'h60, 16'h3008, 8'h80, 8'h00, -1, -1);
        chk("t3_len", done_k, 39 * BT);
        chk("t3_nbits", bits.size(), 37);
        chk("t3_b1", byte_at(9), 'h30);
        chk("t3_b2", byte_at(18), 'h08);
        chk("t3_b3", byte_at(27), 'h80);

        run(1'b0, 1'b0, 8'h42, 16'h0055, 8'hC3, 8'h00,
            12 * BT + 5, -1);
        chk("t4_len", done_k, 30 * BT);
        chk("t4_b1", byte_at(9), 'h55);

        run(1'b0, 1'b0, 8'h60, 16'h00AA, 8'h11, 8'h00,
            -1, 5 * BT + 3);
        run(1'b0, 1'b1, 8'h21, 16'h00F0, 8'h00, 8'hB5, -1, -1);
        chk("t5_rx", byte_at(28), 'hB5);
        chk("t5_rd", int'(rd1), 'hB5);

        for (int n = 0; n < 16; n++) begin
            s  = 1'($urandom);
            r  = 1'($urandom);
            dv = 8'($urandom);
            ad = 16'($urandom);
            dt = 8'($urandom);
            rx = 8'($urandom);
            sp = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(1, 20 * BT)) : -1;
            run(s, r, dv, ad, dt, rx, sp, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
